// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: req/ack bus transactions, pipeline stall, load formatting.
// Optional bus timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall_out,
  output logic              misalign_err,
  output logic              bus_err,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Op attributes needed to format the read word once ack arrives.
  typedef struct packed {
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
    logic       rd;
  } req_t;

  state_t      state;
  req_t        req_q;
  logic        access, misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign access     = op_valid & (mem_read | mem_write);
  assign misaligned = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));

  assign stall_out    = reset & (((state == IDLE) & access & ~misaligned) | (state == BUSY));
  assign misalign_err = reset & (state == IDLE) & access & misaligned;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (size)
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] fmt(input logic [31:0] rdata, input req_t r);
    logic [31:0] sh;
    sh = rdata >> {r.lane, 3'b000};
    case (r.size)
      2'b00:   fmt = r.uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   fmt = r.uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: fmt = rdata;
    endcase
  endfunction

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req_q         <= '0;
      load_data     <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt           <= '0;
      bus_err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (access && !misaligned) begin
          bus.mem_req   <= 1'b1;
          bus.mem_we    <= mem_write & ~mem_read;
          bus.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
          bus.mem_be    <= be_c;
          bus.mem_wdata <= wdata_c;
          req_q         <= '{size: size, uns: load_unsigned, lane: addr[1:0], rd: mem_read};
`ifdef MEM_TIMEOUT_EN
          cnt           <= '0;
`endif
          state         <= BUSY;
        end
        BUSY: if (bus.mem_ack) begin
          bus.mem_req <= 1'b0;
          bus.mem_we  <= 1'b0;
          bus.mem_be  <= '0;
          if (req_q.rd) load_data <= fmt(bus.mem_rdata, req_q);
          state       <= DONE;
        end
`ifdef MEM_TIMEOUT_EN
        // Ack takes priority; abort only when the last allowed cycle also misses it.
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          bus.mem_req <= 1'b0;
          bus.mem_we  <= 1'b0;
          bus.mem_be  <= '0;
          bus_err     <= 1'b1;
          load_data   <= '0;
          state       <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
        DONE: begin
`ifdef MEM_TIMEOUT_EN
          bus_err <= 1'b0;
`endif
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Random and directed load/store ops against an arithmetic byte-lane model of the MEM stage.
module tb_mem_access_unit;
  logic        clk = 1'b0, reset = 1'b0;
  logic        op_valid = 0, mem_read = 0, mem_write = 0, load_unsigned = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, store_data = 0, load_data;
  logic        stall_out, misalign_err, bus_err;
  int          vecs = 0, errs = 0;
  logic [31:0] exp_ld = 0;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_unsigned(load_unsigned), .addr(addr), .store_data(store_data),
    .load_data(load_data), .stall_out(stall_out), .misalign_err(misalign_err),
    .bus_err(bus_err), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // One op: drive at negedge, sample comb outputs #1 later, busy outputs at each negedge.
  task automatic run_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] sd,
                        input int dly, input logic [31:0] rdata);
    int n, off, stalls;
    logic acc, mis;
    logic [31:0] mask, val, ebe, ewd;
    @(negedge clk);
    op_valid = v; mem_read = rd; mem_write = wr; size = sz; load_unsigned = uns;
    addr = a; store_data = sd;
    #1;
    n    = nbytes(sz);
    acc  = v & (rd | wr);
    mis  = (a % n) != 0;
    off  = 8 * (a % 4);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    ebe  = ((32'd1 << n) - 1) << (a % 4);
    ewd  = (n == 1) ? sd[7:0] * 32'h0101_0101 : (n == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    chk("misalign", misalign_err, acc & mis);
    chk("stall_idle", stall_out, acc & ~mis);
    if (!acc || mis) begin
      @(negedge clk);
      chk("no_req", bus.mem_req, 0);
      chk("ld_held", load_data, exp_ld);
      op_valid = 0;
      return;
    end
    stalls = 1;
    for (int c = 0; c <= dly; c++) begin
      @(negedge clk);
      chk("req", bus.mem_req, 1);
      chk("we", bus.mem_we, wr & ~rd);
      chk("addr", bus.mem_addr, a & ~32'd3);
      chk("be", bus.mem_be, ebe);
      chk("wdata", bus.mem_wdata, ewd);
      stalls += stall_out;
      if (c == dly) begin bus.mem_ack = 1; bus.mem_rdata = rdata; end
    end
    @(negedge clk);
    bus.mem_ack = 0; bus.mem_rdata = $urandom;
    if (rd) begin
      val = (rdata >> off) & mask;
      if (!uns && val[8 * n - 1]) val = val | ~mask;
      exp_ld = val;
    end
    chk("stall_cnt", stalls, dly + 2);
    chk("stall_done", stall_out, 0);
    chk("req_drop", {bus.mem_req, bus.mem_we, bus.mem_be}, 0);
    chk("load_data", load_data, exp_ld);
    chk("bus_err", bus_err, 0);
    op_valid = 0;
  endtask

  initial begin
    bus.mem_ack = 0; bus.mem_rdata = 0;
    op_valid = 1; mem_read = 1;
    #12;
    chk("rst_stall", stall_out, 0);
    chk("rst_mis", misalign_err, 0);
    chk("rst_bus", {bus.mem_req, bus.mem_we, bus.mem_be}, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_ld", load_data, 0);
    op_valid = 0;
    @(negedge clk); reset = 1;

    run_op(1, 1, 0, 2'b10, 0, 32'h100, 0, 1, 32'h8899_AABB);
    run_op(1, 1, 0, 2'b00, 0, 32'h103, 0, 0, 32'h80FF_FFFF);
    run_op(1, 1, 0, 2'b00, 1, 32'h103, 0, 0, 32'h80FF_FFFF);
    run_op(1, 0, 1, 2'b01, 0, 32'h22, 32'h1234_ABCD, 0, 32'hDEAD_BEEF);
    run_op(1, 1, 0, 2'b10, 0, 32'h102, 0, 0, 0);
    run_op(1, 1, 1, 2'b01, 0, 32'h42, 32'h5555_5555, 2, 32'h8001_7FFF);
    run_op(1, 1, 0, 2'b11, 1, 32'h200, 0, 0, 32'hCAFE_F00D);

    // Reset during BUSY aborts the transaction and a late ack is ignored.
    @(negedge clk);
    op_valid = 1; mem_read = 1; mem_write = 0; size = 2'b10; addr = 32'h300;
    @(negedge clk);
    chk("busy_req", bus.mem_req, 1);
    reset = 0; #1;
    chk("rst_mid_req", bus.mem_req, 0);
    chk("rst_mid_stall", stall_out, 0);
    op_valid = 0;
    @(negedge clk); bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
    @(negedge clk); bus.mem_ack = 0; reset = 1;
    exp_ld = 0;
    chk("rst_mid_ld", load_data, 0);
    run_op(1, 1, 0, 2'b01, 0, 32'h301, 0, 0, 0);
    @(negedge clk);
    chk("rst_ack_ign", load_data, 0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = 2'($urandom);
      a  = $urandom;
      if ($urandom_range(3) != 0) a = a & ~32'(nbytes(sz) - 1);
      run_op($urandom_range(7) != 0, 1'($urandom), 1'($urandom), sz, 1'($urandom), a,
             $urandom, $urandom_range(2), $urandom);
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int busy;
      exp_ld = 32'hFFFF_FFFF;
      run_op(1, 1, 0, 2'b10, 0, 32'h40, 0, 0, 32'hFFFF_FFFF);
      @(negedge clk);
      op_valid = 1; mem_read = 1; mem_write = 0; size = 2'b10; addr = 32'h44;
      busy = 0;
      for (int c = 0; c < 10 && (c == 0 || bus.mem_req); c++) begin
        @(negedge clk);
        if (bus.mem_req) busy++;
      end
      chk("to_busy_cycles", busy, 4);
      chk("to_bus_err", bus_err, 1);
      chk("to_ld", load_data, 0);
      chk("to_stall", stall_out, 0);
      op_valid = 0;
      @(negedge clk);
      chk("to_err_pulse", bus_err, 0);
      exp_ld = 0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
